mult_sequencer: RTL and testbench

Control FSM for the shift-and-add multiplier. It sequences the datapath: operand load, conditional add, shift. It also drives the bit counter's `RESET` and `DECREMENT` strobes and reads back `count` to decide when the multiplication is finished. It sits between the top-level start/done handshake and the counter plus accumulator/shift-register datapath.

---
 rtl/mult_sequencer.sv | 113 +++++++++++
 tb/tb_mult_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// Control FSM for the shift-and-add multiplier: sequences operand load, conditional
// add and shift, drives the bit counter strobes and signals completion.
module mult_sequencer #(
    parameter int unsigned N  = 4,
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          START,
    input  logic          ABORT,
    input  logic          Q0,
    input  logic [CW-1:0] count,
    output logic          LOAD,
    output logic          RESET,
    output logic          ADD,
    output logic          SHIFT,
    output logic          DECREMENT,
    output logic          READY,
    output logic          DONE
);

    if (CW < $clog2(N + 1)) begin : g_cw_too_narrow
        $error("mult_sequencer: CW too narrow to hold N");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_TEST,
        S_ADD,
        S_SHIFT,
        S_WAIT,
        S_CHECK,
        S_FIN
    } state_t;

    state_t state_q;
    state_t state_d;

    logic load_d;
    logic reset_cnt_d;
    logic add_d;
    logic shift_d;
    logic dec_d;
    logic ready_d;
    logic done_d;

    // Next state, then outputs decoded from it so the registered outputs track the state register
    always_comb begin
        state_d     = state_q;
        load_d      = 1'b0;
        reset_cnt_d = 1'b0;
        add_d       = 1'b0;
        shift_d     = 1'b0;
        dec_d       = 1'b0;
        ready_d     = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE:  if (START) state_d = S_INIT;
            S_INIT:  state_d = S_TEST;
            S_TEST:  state_d = Q0 ? S_ADD : S_SHIFT;
            S_ADD:   state_d = S_SHIFT;
            S_SHIFT: state_d = S_WAIT;
            S_WAIT:  state_d = S_CHECK;
            S_CHECK: state_d = (count == '0) ? S_FIN : S_TEST;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (ABORT && (state_q != S_IDLE) && (state_q != S_FIN)) begin
            state_d = S_IDLE;
        end

        case (state_d)
            S_IDLE:  ready_d = 1'b1;
            S_INIT: begin
                load_d      = 1'b1;
                reset_cnt_d = 1'b1;
            end
            S_ADD:   add_d = 1'b1;
            S_SHIFT: begin
                shift_d = 1'b1;
                dec_d   = 1'b1;
            end
            S_FIN:   done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            LOAD      <= 1'b0;
            RESET     <= 1'b0;
            ADD       <= 1'b0;
            SHIFT     <= 1'b0;
            DECREMENT <= 1'b0;
            READY     <= 1'b1;
            DONE      <= 1'b0;
        end else begin
            state_q   <= state_d;
            LOAD      <= load_d;
            RESET     <= reset_cnt_d;
            ADD       <= add_d;
            SHIFT     <= shift_d;
            DECREMENT <= dec_d;
            READY     <= ready_d;
            DONE      <= done_d;
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: behavioural counter and shift-add datapath around two
// instances (N=4 and N=2), table-driven cycle vectors plus full multiplications.
module tb_mult_sequencer;

    localparam int unsigned N   = 4;
    localparam int unsigned CW  = 3;
    localparam int unsigned N2  = 2;
    localparam int unsigned CW2 = 2;

    localparam logic [6:0] O_IDLE  = 7'b1000000;
    localparam logic [6:0] O_INIT  = 7'b0110000;
    localparam logic [6:0] O_SHIFT = 7'b0000110;
    localparam logic [6:0] O_NONE  = 7'b0000000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic start2 = 1'b0;

    // N=4 instance and its environment
    logic          q0;
    logic [CW-1:0] cnt = '0;
    logic load, rst_cnt, add, shift, dec, ready, done;
    logic [6:0] outv;
    assign outv = {ready, load, rst_cnt, add, shift, dec, done};

    mult_sequencer #(.N(N), .CW(CW)) dut (
        .clk(clk), .reset(reset), .START(start), .ABORT(abort), .Q0(q0), .count(cnt),
        .LOAD(load), .RESET(rst_cnt), .ADD(add), .SHIFT(shift), .DECREMENT(dec),
        .READY(ready), .DONE(done)
    );

    logic [3:0] a = '0, q = '0, m = '0, mcand = '0, mplier = '0;
    logic c = 1'b0, prev_dec = 1'b0;
    assign q0 = q[0];

    always @(posedge clk) begin
        if (load) begin
            a <= '0; c <= 1'b0; q <= mplier; m <= mcand;
        end else if (add) begin
            {c, a} <= {1'b0, a} + {1'b0, m};
        end else if (shift) begin
            {c, a, q} <= {1'b0, c, a, q[3:1]};
        end
        if (rst_cnt) cnt <= CW'(N);
        else if (prev_dec && !dec) cnt <= cnt - 1'b1;
        prev_dec <= dec;
    end

    // N=2 instance and its environment
    logic           q0_2;
    logic [CW2-1:0] cnt2 = '0;
    logic load2, rst_cnt2, add2, shift2, dec2, ready2, done2;
    logic [6:0] outv2;
    assign outv2 = {ready2, load2, rst_cnt2, add2, shift2, dec2, done2};

    mult_sequencer #(.N(N2), .CW(CW2)) dut2 (
        .clk(clk), .reset(reset), .START(start2), .ABORT(1'b0), .Q0(q0_2), .count(cnt2),
        .LOAD(load2), .RESET(rst_cnt2), .ADD(add2), .SHIFT(shift2), .DECREMENT(dec2),
        .READY(ready2), .DONE(done2)
    );

    logic [1:0] a2 = '0, q2 = '0, m2 = '0;
    logic c2 = 1'b0, prev_dec2 = 1'b0;
    assign q0_2 = q2[0];

    always @(posedge clk) begin
        if (load2) begin
            a2 <= '0; c2 <= 1'b0; q2 <= 2'b11; m2 <= 2'b11;
        end else if (add2) begin
            {c2, a2} <= {1'b0, a2} + {1'b0, m2};
        end else if (shift2) begin
            {c2, a2, q2} <= {1'b0, c2, a2, q2[1]};
        end
        if (rst_cnt2) cnt2 <= CW2'(N2);
        else if (prev_dec2 && !dec2) cnt2 <= cnt2 - 1'b1;
        prev_dec2 <= dec2;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic       st;
        logic       ab;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[16];

    // One full N=4 operation: START pulse, then cycle count from INIT to DONE and strobe tallies
    task automatic run_op(input logic [3:0] mc, input logic [3:0] mp, input int exp_cyc,
                          input int exp_add, input bit busy_start, input string tag);
        int cyc, loads, adds, shifts, decs;
        mcand = mc; mplier = mp;
        start = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_init"}, 32'(outv), 32'(O_INIT));
        cyc = 1; loads = 0; adds = 0; shifts = 0; decs = 0;
        while (!done && cyc < 64) begin
            if (load)  loads++;
            if (add)   adds++;
            if (shift) shifts++;
            if (dec)   decs++;
            if (busy_start) start = (cyc % 3 == 0);
            step();
            cyc++;
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_loads"}, 32'(loads), 32'd1);
        check({tag, "_adds"}, 32'(adds), 32'(exp_add));
        check({tag, "_shifts"}, 32'(shifts), 32'(N));
        check({tag, "_decs"}, 32'(decs), 32'(N));
        check({tag, "_product"}, 32'({a, q}), 32'(mc) * 32'(mp));
        check({tag, "_count"}, 32'(cnt), 32'd0);
        step();
        check({tag, "_after_done"}, 32'(outv), 32'(O_IDLE));
    endtask

    task automatic count_to_done2(output int cyc, output int shifts);
        cyc = 1; shifts = 0;
        while (!done2 && cyc < 64) begin
            if (shift2) shifts++;
            step();
            cyc++;
        end
    endtask

    initial begin
        int cyc, shifts;
        bit seen;

        mcand = 4'd3; mplier = 4'b0010;
        // Reset (with START/ABORT also high), idle, then an op aborted in its second TEST
        tbl[0]  = '{1'b1, 1'b1, 1'b1, O_IDLE};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, O_IDLE};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, O_IDLE};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, O_IDLE};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, O_IDLE};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, O_IDLE};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, O_IDLE};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, O_INIT};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, O_NONE};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, O_SHIFT};
        tbl[10] = '{1'b0, 1'b0, 1'b0, O_NONE};
        tbl[11] = '{1'b0, 1'b0, 1'b0, O_NONE};
        tbl[12] = '{1'b0, 1'b1, 1'b0, O_NONE};
        tbl[13] = '{1'b0, 1'b0, 1'b1, O_IDLE};
        tbl[14] = '{1'b0, 1'b0, 1'b0, O_IDLE};
        tbl[15] = '{1'b0, 1'b0, 1'b1, O_IDLE};

        for (int i = 0; i < 16; i++) begin
            reset = tbl[i].rst; start = tbl[i].st; abort = tbl[i].ab;
            step();
            check($sformatf("vec%0d", i), 32'(outv), 32'(tbl[i].exp));
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        step();

        run_op(4'd9, 4'b0000, 18, 0, 1'b0, "mul9x0");
        run_op(4'd13, 4'b1011, 21, 3, 1'b1, "mul13x11");

        // Reset while in WAIT, then a clean 15x15
        mcand = 4'd15; mplier = 4'd15;
        start = 1'b1;
        step();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = shift;
        end
        check("rst_wait_shift_seen", 32'(seen), 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_wait_idle", 32'(outv), 32'(O_IDLE));
        step();
        check("rst_wait_still_idle", 32'(outv), 32'(O_IDLE));
        run_op(4'd15, 4'd15, 22, 4, 1'b0, "mul15x15");

        // N=2 with START held: back-to-back operations
        start2 = 1'b1;
        step();
        check("n2_init", 32'(outv2), 32'(O_INIT));
        count_to_done2(cyc, shifts);
        check("n2_done_cycle", 32'(cyc), 32'd12);
        check("n2_shifts", 32'(shifts), 32'd2);
        check("n2_product", 32'({a2, q2}), 32'd9);
        step();
        check("n2_idle_gap", 32'(outv2), 32'(O_IDLE));
        step();
        check("n2_reinit", 32'(outv2), 32'(O_INIT));
        start2 = 1'b0;
        count_to_done2(cyc, shifts);
        check("n2_second_done_cycle", 32'(cyc), 32'd12);
        step();
        check("n2_final_idle", 32'(outv2), 32'(O_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
